// File: rtl/exec_pkg.sv
// Shared definitions for the multi-cycle execute stage: opcodes, FSM states
// and the immediate-extension helper.
package exec_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b0010;
  localparam logic [3:0] OP_LOAD  = 4'b0011;
  localparam logic [3:0] OP_STORE = 4'b0100;
  localparam logic [3:0] OP_BEQ   = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b0110;
  localparam logic [3:0] OP_JAL   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_NOP   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Widest vector ext_imm can produce; callers truncate with a size cast.
  localparam int EXT_W = 64;

  function automatic logic [EXT_W-1:0] ext_imm(input logic [EXT_W-1:0] imm,
                                               input int imm_w,
                                               input bit sext);
    logic [EXT_W-1:0] r;
    logic             sign;
    sign = sext & imm[imm_w-1];
    for (int i = 0; i < EXT_W; i++) begin
      r[i] = (i < imm_w) ? imm[i] : sign;
    end
    return r;
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) ||
           (op == OP_LOAD) || (op == OP_JAL) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/exec_mul_seq.sv
// Shift-add multiplier: bit 0 is consumed while loading, then one multiplier
// bit per cycle; o_done pulses for one cycle once all XLEN bits are in.
module exec_mul_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_product
);

  localparam int CNT_W = $clog2(XLEN + 1);

  logic [XLEN-1:0]  r_mcand;
  logic [XLEN-1:0]  r_mplier;
  logic [XLEN-1:0]  r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  // NOTE: sequential state is written with <= only, so every register sees the
  // pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_acc    <= i_b[0] ? i_a : '0;
        r_mcand  <= i_a << 1;
        r_mplier <= i_b >> 1;
        r_cnt    <= CNT_W'(XLEN - 1);
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_acc;

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle handshaked execute stage: single-cycle ALU/branch ops, a req/ack
// data-memory port, an iterative multiplier and a sticky HALT.
module exec_unit_mc
  import exec_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PC_W     = 16,
  parameter int IMM_W    = 16,
  parameter bit IMM_SEXT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [3:0]       rd,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_rd,
  output logic [XLEN-1:0]  rd_value,
  output logic             reg_write_en,
  output logic             branch_taken,
  output logic [PC_W-1:0]  branch_target,
  output logic             halt,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_ack,
  input  logic [XLEN-1:0]  mem_rdata
);

  state_e r_state, w_state_nxt;

  logic            r_halted;
  logic [3:0]      r_rd;
  logic [XLEN-1:0] r_rd_value;
  logic            r_wen;
  logic            r_taken;
  logic [PC_W-1:0] r_target;
  logic            r_halt;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;

  logic            w_xfer;
  logic            w_out_valid;
  logic            w_accept;
  logic            w_is_mem;
  logic            w_is_mul;
  logic [XLEN-1:0] w_ext_x;
  logic [PC_W-1:0] w_ext_pc;
  logic [XLEN-1:0] w_res;
  logic            w_taken;
  logic [PC_W-1:0] w_target;
  logic            w_halt;
  logic            w_mul_busy;
  logic            w_mul_done;
  logic [XLEN-1:0] w_mul_product;

  assign w_ext_x     = XLEN'(ext_imm(EXT_W'(imm), IMM_W, IMM_SEXT));
  assign w_ext_pc    = PC_W'(ext_imm(EXT_W'(imm), IMM_W, IMM_SEXT));
  assign w_is_mem    = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign w_is_mul    = (opcode == OP_MUL);
  assign w_out_valid = (r_state == ST_DONE);
  assign w_accept    = w_out_valid & out_ready;
  assign in_ready    = (r_state == ST_IDLE) & ~r_halted & ~w_mul_busy;
  assign w_xfer      = in_valid & in_ready;

  // NOTE: every always_comb output gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_res    = '0;
    w_taken  = 1'b0;
    w_target = pc + w_ext_pc;
    w_halt   = 1'b0;
    case (opcode)
      OP_ADD:  w_res = rs1_val + rs2_val;
      OP_SUB:  w_res = rs1_val - rs2_val;
      OP_ADDI: w_res = rs1_val + w_ext_x;
      OP_BEQ:  w_taken = (rs1_val == rs2_val);
      OP_HALT: w_halt = 1'b1;
      OP_JAL: begin
        w_res   = XLEN'(pc);
        w_taken = 1'b1;
      end
      default: ;
    endcase
  end

  exec_mul_seq #(.XLEN(XLEN)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_xfer & w_is_mul),
    .i_a       (rs1_val),
    .i_b       (rs2_val),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_xfer) begin
        if (w_is_mem)      w_state_nxt = ST_MEM;
        else if (w_is_mul) w_state_nxt = ST_MUL;
        else               w_state_nxt = ST_DONE;
      end
      ST_MEM:  if (mem_ack)    w_state_nxt = ST_DONE;
      ST_MUL:  if (w_mul_done) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted    <= 1'b0;
      r_rd        <= '0;
      r_rd_value  <= '0;
      r_wen       <= 1'b0;
      r_taken     <= 1'b0;
      r_target    <= '0;
      r_halt      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_xfer) begin
        r_rd       <= rd;
        r_rd_value <= w_res;
        r_wen      <= writes_rd(opcode) && (rd != 4'd0);
        r_taken    <= w_taken;
        r_target   <= w_target;
        r_halt     <= w_halt;
        if (w_is_mem) begin
          r_mem_req   <= 1'b1;
          r_mem_we    <= (opcode == OP_STORE);
          r_mem_addr  <= rs1_val + w_ext_x;
          r_mem_wdata <= rs2_val;
        end
      end
      // mem_req is high for the whole MEM state, so ack is only seen while requested.
      if (r_state == ST_MEM && mem_ack) begin
        r_mem_req <= 1'b0;
        if (!r_mem_we) r_rd_value <= mem_rdata;
      end
      if (r_state == ST_MUL && w_mul_done) r_rd_value <= w_mul_product;
      if (w_accept && r_halt) r_halted <= 1'b1;
    end
  end

  // Result fields read as zero whenever no result is being offered.
  assign out_valid     = w_out_valid;
  assign out_rd        = w_out_valid ? r_rd : '0;
  assign rd_value      = w_out_valid ? r_rd_value : '0;
  assign reg_write_en  = w_out_valid & r_wen;
  assign branch_taken  = w_out_valid & r_taken;
  assign branch_target = w_out_valid ? r_target : '0;
  assign halt          = w_out_valid & r_halt;
  assign mem_req       = r_mem_req;
  assign mem_we        = r_mem_req & r_mem_we;
  assign mem_addr      = r_mem_req ? r_mem_addr : '0;
  assign mem_wdata     = r_mem_req ? r_mem_wdata : '0;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Randomized self-checking bench for exec_unit_mc against an arithmetic
// reference model, plus directed latency, backpressure, halt and reset cases.
module tb_exec_unit_mc;

  localparam int XLEN     = 32;
  localparam int PC_W     = 16;
  localparam int IMM_W    = 16;
  localparam bit IMM_SEXT = 1'b0;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic [3:0]       rd;
  logic [IMM_W-1:0] imm;
  logic [PC_W-1:0]  pc;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_rd;
  logic [XLEN-1:0]  rd_value;
  logic             reg_write_en;
  logic             branch_taken;
  logic [PC_W-1:0]  branch_target;
  logic             halt;
  logic             mem_req;
  logic             mem_we;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_wdata;
  logic             mem_ack;
  logic [XLEN-1:0]  mem_rdata;

  always #5 clk = ~clk;

  exec_unit_mc #(
    .XLEN(XLEN), .PC_W(PC_W), .IMM_W(IMM_W), .IMM_SEXT(IMM_SEXT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs1_val(rs1_val), .rs2_val(rs2_val), .rd(rd),
    .imm(imm), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .rd_value(rd_value), .reg_write_en(reg_write_en),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        wen;
    logic [63:0] val;
    logic        has_val;
    logic        taken;
    logic [63:0] target;
    logic        has_target;
    logic        halt;
    logic        is_mem;
    logic        is_store;
    logic [63:0] addr;
    int          latency;
  } exp_t;

  // Reference model: behaviour from the opcode table with plain 64-bit arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] rd_i, input logic [15:0] im,
                                 input logic [15:0] p, input logic [31:0] rdata, input int ack_dly);
    exp_t        m;
    logic [63:0] e, xm, pm;
    xm = (64'd1 << XLEN) - 64'd1;
    pm = (64'd1 << PC_W) - 64'd1;
    e  = 64'(im);
    if (IMM_SEXT && im[IMM_W-1]) e = e - (64'd1 << IMM_W);
    m            = '0;
    m.latency    = 1;
    m.target     = (64'(p) + e) & pm;
    m.addr       = (64'(a) + e) & xm;
    case (op)
      4'd0: begin m.val = (64'(a) - 64'(0) + 64'(b)) & xm; m.has_val = 1; m.wen = 1; end
      4'd1: begin m.val = (64'(a) - 64'(b)) & xm; m.has_val = 1; m.wen = 1; end
      4'd2: begin m.val = (64'(a) + e) & xm; m.has_val = 1; m.wen = 1; end
      4'd3: begin
        m.val = 64'(rdata); m.has_val = 1; m.wen = 1; m.is_mem = 1; m.latency = ack_dly + 2;
      end
      4'd4: begin m.is_mem = 1; m.is_store = 1; m.latency = ack_dly + 2; end
      4'd5: begin m.taken = (a == b); m.has_target = 1; end
      4'd6: m.halt = 1;
      4'd7: begin m.val = 64'(p); m.has_val = 1; m.wen = 1; m.taken = 1; m.has_target = 1; end
      4'd8: begin m.val = (64'(a) * 64'(b)) & xm; m.has_val = 1; m.wen = 1; m.latency = XLEN + 1; end
      default: ;
    endcase
    if (rd_i == 4'd0) m.wen = 0;
    return m;
  endfunction

  task automatic check_result(input exp_t m, input logic [3:0] rd_i, input string sfx);
    check({"out_valid", sfx}, 64'(out_valid), 64'd1);
    check({"in_ready_busy", sfx}, 64'(in_ready), 64'd0);
    check({"out_rd", sfx}, 64'(out_rd), 64'(rd_i));
    check({"reg_write_en", sfx}, 64'(reg_write_en), 64'(m.wen));
    check({"branch_taken", sfx}, 64'(branch_taken), 64'(m.taken));
    check({"halt", sfx}, 64'(halt), 64'(m.halt));
    if (m.has_val) check({"rd_value", sfx}, 64'(rd_value), m.val);
    if (m.has_target) check({"branch_target", sfx}, 64'(branch_target), m.target);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] rd_i, input logic [15:0] im, input logic [15:0] p,
                        input int ack_dly, input logic [31:0] rdata, input int bp);
    exp_t m;
    int   lat;
    int   wait_n;
    m = model(op, a, b, rd_i, im, p, rdata, ack_dly);
    wait_n = 0;
    while (!in_ready && wait_n < 100) begin
      step();
      wait_n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1; opcode = op; rs1_val = a; rs2_val = b; rd = rd_i; imm = im; pc = p;
    step();
    in_valid = 1'b0;
    opcode = 4'($urandom); rs1_val = $urandom; rs2_val = $urandom;
    rd = 4'($urandom); imm = 16'($urandom); pc = 16'($urandom);
    lat = 1;
    wait_n = 0;
    while (!out_valid && lat < 200) begin
      check("mem_req", 64'(mem_req), 64'(m.is_mem));
      check("in_ready_wait_result", 64'(in_ready), 64'd0);
      if (mem_req) begin
        check("mem_addr", 64'(mem_addr), m.addr);
        check("mem_we", 64'(mem_we), 64'(m.is_store));
        if (m.is_store) check("mem_wdata", 64'(mem_wdata), 64'(b));
        if (wait_n == ack_dly) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end else begin
          wait_n++;
        end
      end
      step();
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      lat++;
    end
    check("latency", 64'(lat), 64'(m.latency));
    check_result(m, rd_i, "");
    for (int i = 0; i < bp; i++) begin
      step();
      check_result(m, rd_i, "_held");
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_cleared", 64'(out_valid), 64'd0);
    check("rd_value_cleared", 64'(rd_value), 64'd0);
    check("in_ready_after", 64'(in_ready), 64'(!m.halt));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_outs"}, {out_rd, rd_value, reg_write_en, branch_taken, branch_target, halt}, 64'd0);
    check({tag, "_mem"}, {mem_req, mem_we, mem_addr[30:0]}, 64'd0);
    check({tag, "_mem_hi"}, {mem_addr[31], mem_wdata}, 64'd0);
  endtask

  task automatic start_op(input logic [3:0] op);
    in_valid = 1'b1; opcode = op; rs1_val = 32'h123; rs2_val = 32'h45; rd = 4'd6;
    imm = 16'h8; pc = 16'h0;
    step();
    in_valid = 1'b0;
  endtask

  logic [3:0] ops [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd15, 4'd9, 4'd12};

  initial begin
    int stale;
    logic [31:0] a, b;
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; rs1_val = '0; rs2_val = '0; rd = '0;
    imm = '0; pc = '0; out_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    step();
    step();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step();

    run_op(4'd0, 32'd7, 32'd5, 4'd3, 16'd0, 16'd0, 0, 32'd0, 0);
    run_op(4'd3, 32'h100, 32'd0, 4'd5, 16'd4, 16'd0, 3, 32'hDEAD, 0);
    run_op(4'd8, 32'hFFFF_FFFF, 32'd3, 4'd2, 16'd0, 16'd0, 0, 32'd0, 0);
    run_op(4'd5, 32'd9, 32'd9, 4'd0, 16'h20, 16'hFFF0, 0, 32'd0, 0);
    run_op(4'd7, 32'd0, 32'd0, 4'd1, 16'd8, 16'h40, 0, 32'd0, 0);
    run_op(4'd1, 32'd3, 32'd5, 4'd4, 16'd0, 16'd0, 0, 32'd0, 4);
    run_op(4'd4, 32'hFFFF_FFF0, 32'hCAFE, 4'd7, 16'h20, 16'd0, 0, 32'd0, 1);
    run_op(4'd0, 32'd1, 32'd1, 4'd0, 16'd0, 16'd0, 0, 32'd0, 0);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? a : $urandom;
      run_op(ops[$urandom_range(0, 10)], a, b, 4'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(0, 4), $urandom, $urandom_range(0, 3));
    end

    // Reset in the middle of a multiply.
    start_op(4'd8);
    repeat (10) step();
    rst_n = 1'b0;
    #2;
    check_idle_outputs("rst_mul");
    step();
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) stale++;
    end
    check("rst_mul_no_stale", 64'(stale), 64'd0);

    // Reset while a load waits for its ack.
    start_op(4'd3);
    step();
    check("rst_mem_req_before", 64'(mem_req), 64'd1);
    rst_n = 1'b0;
    #2;
    check_idle_outputs("rst_mem");
    step();
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid || mem_req) stale++;
    end
    check("rst_mem_no_stale", 64'(stale), 64'd0);
    run_op(4'd2, 32'd10, 32'd0, 4'd9, 16'hFFFF, 16'd0, 0, 32'd0, 0);

    // HALT is sticky: later ops are never accepted.
    run_op(4'd6, 32'd0, 32'd0, 4'd0, 16'd0, 16'd0, 0, 32'd0, 2);
    in_valid = 1'b1; opcode = 4'd0; rd = 4'd2;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (in_ready || out_valid) stale++;
    end
    in_valid = 1'b0;
    check("halt_sticky", 64'(stale), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
